// File: rtl/picomips_pkg.sv
// picomips_pkg
//   Shared types for the picoMIPS control path: opcode encoding, ALU
//   function select, FSM state codes and the decoded control bundle that
//   ctrl_decode hands to pc_ctrl_fsm.
package picomips_pkg;

    // Opcode occupies the top OP_W bits of every instruction word.
    localparam int OP_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUB  = 4'h3,
        OP_SUBI = 4'h4,
        OP_MUL  = 4'h5,
        OP_MULI = 4'h6,
        OP_BEQ  = 4'h7,
        OP_BNE  = 4'h8,
        OP_BR   = 4'h9,
        OP_IN   = 4'hA,
        OP_OUT  = 4'hB,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_MUL   = 2'b10,
        ALU_PASSB = 2'b11
    } alu_fn_t;

    // State codes kept as plain constants so legacy tooling that matches on
    // raw state values keeps working.
    typedef logic [2:0] state_t;
    localparam state_t S_FETCH = 3'd0;
    localparam state_t S_EXEC  = 3'd1;
    localparam state_t S_IN    = 3'd2;
    localparam state_t S_OUT   = 3'd3;
    localparam state_t S_HALT  = 3'd4;

    // Everything the EXEC cycle needs to know about the latched instruction.
    typedef struct packed {
        logic    reg_we;   // ALU result written back
        logic    zf_we;    // zflag captures alu_zero
        logic    pc_incr;  // PC action: PC+1
        logic    pc_rel;   // PC action: PC+Branchaddr
        logic    imm_sel;  // ALU B operand is the immediate
        alu_fn_t alu_fn;
        logic    bad_op;   // undefined opcode
        state_t  nxt;      // state after EXEC
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
//   Purely combinational instruction decoder. Turns the opcode of the
//   latched instruction plus the stored zero flag into the control bundle
//   used during the EXEC cycle.
// Ports
//   op     in   OP_W   opcode field of the instruction register
//   zflag  in   1      zero flag from the last ALU instruction
//   ctrl   out  ctrl_t decoded controls and next FSM state
module ctrl_decode
    import picomips_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            zflag,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.nxt    = S_FETCH;
        ctrl.alu_fn = ALU_ADD;

        case (op)
            OP_NOP: ctrl.pc_incr = 1'b1;

            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MULI: begin
                ctrl.reg_we  = 1'b1;
                ctrl.zf_we   = 1'b1;
                ctrl.pc_incr = 1'b1;
            end

            // Conditional branches: exactly one of the two PC actions.
            OP_BEQ: begin
                ctrl.pc_rel  = zflag;
                ctrl.pc_incr = ~zflag;
            end
            OP_BNE: begin
                ctrl.pc_rel  = ~zflag;
                ctrl.pc_incr = zflag;
            end

            OP_BR:   ctrl.pc_rel = 1'b1;

            // Stalling instructions defer their PC action to the handshake.
            OP_IN:   ctrl.nxt = S_IN;
            OP_OUT:  ctrl.nxt = S_OUT;
            OP_HALT: ctrl.nxt = S_HALT;

            default: begin
                ctrl.bad_op  = 1'b1;
                ctrl.pc_incr = 1'b1;
            end
        endcase

        case (op)
            OP_SUB, OP_SUBI: ctrl.alu_fn = ALU_SUB;
            OP_MUL, OP_MULI: ctrl.alu_fn = ALU_MUL;
            default:         ctrl.alu_fn = ALU_ADD;
        endcase

        case (op)
            OP_ADDI, OP_SUBI, OP_MULI: ctrl.imm_sel = 1'b1;
            default:                   ctrl.imm_sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_ctrl_fsm.sv
// pc_ctrl_fsm
//   Fetch/execute control FSM for picoMIPS. Latches the instruction at
//   PCout, decodes it and drives the pc block (PCincr / PCrelbranch /
//   Branchaddr) together with register-file and ALU controls. Stalls on the
//   IN/OUT handshakes and stops on HALT until reset.
// Ports
//   clk, reset             clock; synchronous active-high reset
//   instr                  program memory word at PCout
//   alu_zero               ALU result is zero (EXEC cycle)
//   in_valid / in_ready    external input handshake
//   out_valid / out_ready  external output handshake (data = reg[rs])
//   PCincr, PCrelbranch    PC actions, mutually exclusive
//   Branchaddr             truncated two's-complement branch offset
//   rd, rs, imm            fields of the latched instruction
//   alu_fn, imm_sel        ALU function and B-operand select
//   in_sel, reg_we         writeback source and enable
//   halted, illegal        HALT reached; sticky undefined-opcode flag
module pc_ctrl_fsm
    import picomips_pkg::*;
#(
    parameter int Psize = 5,
    parameter int Rbits = 3,
    parameter int Dsize = 8,
    parameter int Isize = 4 + 2*Rbits + Dsize
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Isize-1:0] instr,
    input  logic             alu_zero,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             PCincr,
    output logic             PCrelbranch,
    output logic [Psize-1:0] Branchaddr,
    output logic [Rbits-1:0] rd,
    output logic [Rbits-1:0] rs,
    output logic [Dsize-1:0] imm,
    output logic [1:0]       alu_fn,
    output logic             imm_sel,
    output logic             in_sel,
    output logic             reg_we,
    output logic             in_ready,
    output logic             out_valid,
    output logic             halted,
    output logic             illegal
);

    localparam int RS_LSB = Dsize;
    localparam int RD_LSB = Dsize + Rbits;

    state_t           state;
    logic [Isize-1:0] ir;
    logic             zflag;
    logic             illegal_q;
    ctrl_t            ctrl;

    ctrl_decode u_decode (
        .op    (ir[Isize-1 -: OP_W]),
        .zflag (zflag),
        .ctrl  (ctrl)
    );

    // Fields come straight from ir so they stay stable through any stall;
    // OUT data addressed by rs therefore holds until accepted.
    assign rd         = ir[RD_LSB +: Rbits];
    assign rs         = ir[RS_LSB +: Rbits];
    assign imm        = ir[Dsize-1:0];
    assign Branchaddr = ir[Psize-1:0];
    assign illegal    = illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            ir        <= '0;
            zflag     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= instr;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (ctrl.zf_we)  zflag     <= alu_zero;
                    if (ctrl.bad_op) illegal_q <= 1'b1;
                    state <= ctrl.nxt;
                end
                S_IN:    if (in_valid)  state <= S_FETCH;
                S_OUT:   if (out_ready) state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Controls are gated by reset so handshakes and PC actions drop in the
    // reset cycle itself rather than one cycle later.
    always_comb begin
        PCincr      = 1'b0;
        PCrelbranch = 1'b0;
        reg_we      = 1'b0;
        alu_fn      = ALU_ADD;
        imm_sel     = 1'b0;
        in_sel      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        halted      = 1'b0;

        if (!reset) begin
            case (state)
                S_EXEC: begin
                    PCincr      = ctrl.pc_incr;
                    PCrelbranch = ctrl.pc_rel;
                    reg_we      = ctrl.reg_we;
                    alu_fn      = ctrl.alu_fn;
                    imm_sel     = ctrl.imm_sel;
                end
                S_IN: begin
                    in_ready = 1'b1;
                    in_sel   = 1'b1;
                    reg_we   = in_valid;
                    PCincr   = in_valid;
                end
                S_OUT: begin
                    out_valid = 1'b1;
                    PCincr    = out_ready;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_ctrl_fsm.sv
module tb_pc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] instr = '0;
    logic        alu_zero = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        PCincr, PCrelbranch;
    logic [4:0]  Branchaddr;
    logic [2:0]  rd, rs;
    logic [7:0]  imm;
    logic [1:0]  alu_fn;
    logic        imm_sel, in_sel, reg_we, in_ready, out_valid, halted, illegal;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: program counter as the pc block would see it,
    // zero flag and sticky illegal flag.
    logic [4:0] mpc = '0;
    bit         mzf = 1'b0;
    bit         mill = 1'b0;

    // PC reconstructed from the DUT's PC actions.
    logic [4:0] dut_pc;

    logic [9:0]  ctl;
    logic [18:0] fields;
    assign ctl    = {PCincr, PCrelbranch, reg_we, in_ready, in_sel, out_valid, halted, imm_sel, alu_fn};
    assign fields = {rd, rs, imm, Branchaddr};

    pc_ctrl_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .alu_zero    (alu_zero),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .PCincr      (PCincr),
        .PCrelbranch (PCrelbranch),
        .Branchaddr  (Branchaddr),
        .rd          (rd),
        .rs          (rs),
        .imm         (imm),
        .alu_fn      (alu_fn),
        .imm_sel     (imm_sel),
        .in_sel      (in_sel),
        .reg_we      (reg_we),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset)            dut_pc <= '0;
        else if (PCincr)      dut_pc <= dut_pc + 5'd1;
        else if (PCrelbranch) dut_pc <= dut_pc + Branchaddr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Both PC actions at once is never allowed.
    always @(negedge clk) chk("pc_excl", 32'(PCincr & PCrelbranch), 32'd0);

    function automatic logic [9:0] mk(input bit incr, input bit rel, input bit we, input bit ird,
                                      input bit isl, input bit ov, input bit h, input bit ims,
                                      input logic [1:0] fn);
        return {incr, rel, we, ird, isl, ov, h, ims, fn};
    endfunction

    function automatic bit is_taken(input int op, input bit zf);
        return (op == 7 && zf) || (op == 8 && !zf) || op == 9;
    endfunction

    // EXEC-cycle controls from the instruction-set rules.
    function automatic logic [9:0] exp_exec(input int op, input bit zf);
        bit         alu   = (op >= 1 && op <= 6);
        bit         taken = is_taken(op, zf);
        bit         stall = (op == 10 || op == 11 || op == 15);
        logic [1:0] fn    = alu ? 2'((op - 1) / 2) : 2'b00;
        bit         ims   = alu && (op % 2 == 0);
        return mk(!taken && !stall, taken, alu, 1'b0, 1'b0, 1'b0, 1'b0, ims, fn);
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_ctl", 32'(ctl), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mpc = '0; mzf = 1'b0; mill = 1'b0;
        chk("rst_state_ctl", 32'(ctl), 32'd0);
        chk("rst_fields", 32'(fields), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_pc", 32'(dut_pc), 32'(mpc));
    endtask

    // One instruction, starting #1 after the edge that entered FETCH.
    // w: wait cycles for IN/OUT, or cycles to observe HALT.
    // abort: reset instead of completing the IN/OUT handshake.
    task automatic run_instr(input int op, input logic [2:0] t_rd, input logic [2:0] t_rs,
                             input logic [7:0] t_imm, input bit az, input int w, input bit abort);
        bit taken;
        instr = {4'(op), t_rd, t_rs, t_imm};
        in_valid = 1'b0; out_ready = 1'b0; alu_zero = 1'($urandom);
        @(negedge clk);
        chk("fetch_ctl", 32'(ctl), 32'd0);
        @(posedge clk); #1;
        instr = 18'($urandom);
        alu_zero = az;
        if (w == 0 && !abort) begin
            in_valid  = (op == 10);
            out_ready = (op == 11);
        end
        @(negedge clk);
        chk("exec_ctl", 32'(ctl), 32'(exp_exec(op, mzf)));
        chk("exec_fields", 32'(fields), 32'({t_rd, t_rs, t_imm, t_imm[4:0]}));
        chk("exec_illegal", 32'(illegal), 32'(mill));
        taken = is_taken(op, mzf);
        @(posedge clk); #1;
        if (op >= 1 && op <= 6)   mzf = az;
        if (op >= 12 && op <= 14) mill = 1'b1;

        if (op == 10 || op == 11) begin
            for (int i = 0; i < w; i++) begin
                in_valid = 1'b0; out_ready = 1'b0;
                @(negedge clk);
                if (op == 10) chk("in_wait", 32'(ctl), 32'(mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00)));
                else          chk("out_wait", 32'(ctl), 32'(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00)));
                chk("wait_fields", 32'(fields), 32'({t_rd, t_rs, t_imm, t_imm[4:0]}));
                @(posedge clk); #1;
            end
            if (abort) begin
                chk("abort_pc", 32'(dut_pc), 32'(mpc));
                do_reset();
                return;
            end
            in_valid  = (op == 10);
            out_ready = (op == 11);
            @(negedge clk);
            if (op == 10) chk("in_accept", 32'(ctl), 32'(mk(1, 0, 1, 1, 1, 0, 0, 0, 2'b00)));
            else          chk("out_accept", 32'(ctl), 32'(mk(1, 0, 0, 0, 0, 1, 0, 0, 2'b00)));
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b0;
        end else if (op == 15) begin
            for (int i = 0; i < w; i++) begin
                @(negedge clk);
                chk("halt_ctl", 32'(ctl), 32'(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00)));
                @(posedge clk); #1;
            end
            chk("halt_pc", 32'(dut_pc), 32'(mpc));
            do_reset();
            return;
        end

        if (taken) mpc = mpc + t_imm[4:0];
        else       mpc = mpc + 5'd1;
        chk("pc", 32'(dut_pc), 32'(mpc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // ADDI r1,5 then BEQ +3 with zflag clear: PC 0 -> 1 -> 2
        run_instr(2, 3'd1, 3'd0, 8'd5, 1'b0, 0, 1'b0);
        run_instr(7, 3'd0, 3'd0, 8'd3, 1'b0, 0, 1'b0);
        // SUB sets zflag; BNE -2 not taken, BEQ -2 taken (Branchaddr 1E)
        run_instr(3, 3'd2, 3'd1, 8'd0, 1'b1, 0, 1'b0);
        run_instr(8, 3'd0, 3'd0, 8'hFE, 1'b0, 0, 1'b0);
        run_instr(7, 3'd0, 3'd0, 8'hFE, 1'b0, 0, 1'b0);
        // BR with zero offset is a self-loop
        run_instr(9, 3'd0, 3'd0, 8'h00, 1'b0, 0, 1'b0);
        // IN waits 5 cycles, OUT waits 3, IN with in_valid already high
        run_instr(10, 3'd3, 3'd0, 8'd0, 1'b0, 5, 1'b0);
        run_instr(11, 3'd0, 3'd3, 8'd0, 1'b0, 3, 1'b0);
        run_instr(10, 3'd4, 3'd0, 8'd0, 1'b0, 0, 1'b0);
        // Undefined opcode sets sticky flag; next instruction still sees it
        run_instr(13, 3'd0, 3'd0, 8'd0, 1'b0, 0, 1'b0);
        run_instr(0, 3'd0, 3'd0, 8'd0, 1'b0, 0, 1'b0);
        // HALT held 20 cycles, then reset
        run_instr(15, 3'd0, 3'd0, 8'd0, 1'b0, 20, 1'b0);
        // Reset during IN and OUT stalls
        run_instr(10, 3'd1, 3'd0, 8'd0, 1'b0, 2, 1'b1);
        run_instr(11, 3'd0, 3'd1, 8'd0, 1'b0, 0, 1'b1);

        for (int n = 0; n < 250; n++) begin
            int op;
            int w;
            bit ab;
            op = $urandom_range(0, 15);
            w  = (op == 15) ? $urandom_range(1, 4) : $urandom_range(0, 3);
            ab = (op == 10 || op == 11) && ($urandom_range(0, 7) == 0);
            run_instr(op, 3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), w, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
